// File: rtl/exec_decode_pkg.sv
// Shared opcode, ALUOp and ALU control encodings for the execute/decode unit.
// MUL decode is gated by the ALU_MUL_EN macro.
package exec_decode_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [9:0] F_AND = 10'b0000000_111;
   localparam logic [9:0] F_XOR = 10'b0000000_100;
   localparam logic [9:0] F_SLL = 10'b0000000_001;
   localparam logic [9:0] F_ADD = 10'b0000000_000;
   localparam logic [9:0] F_SUB = 10'b0100000_000;
   localparam logic [9:0] F_MUL = 10'b0000001_000;

   typedef enum logic [1:0] {
      ALUOP_MEM = 2'b00,
      ALUOP_BR  = 2'b01,
      ALUOP_R   = 2'b10,
      ALUOP_I   = 2'b11
   } aluop_e;

   typedef enum logic [2:0] {
      ALU_AND  = 3'b000,
      ALU_XOR  = 3'b001,
      ALU_SLL  = 3'b010,
      ALU_ADD  = 3'b011,
      ALU_SUB  = 3'b100,
      ALU_MUL  = 3'b101,
      ALU_SRA  = 3'b110,
      ALU_NONE = 3'b111
   } aluctl_e;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
      logic memread;
      logic memwrite;
      logic branch;
   } ctrl_t;

endpackage

// File: rtl/exec_decode_unit_if.sv
// Instruction/operand inputs and registered results of the execute/decode unit.
// Used by the top with or without ALU_MUL_EN.
interface exec_decode_unit_if #(
   parameter int DATA_W = 32
);

   logic [6:0]        op_i;
   logic              noop_i;
   logic [9:0]        funct_i;
   logic [DATA_W-1:0] rs1_data_i;
   logic [DATA_W-1:0] rs2_data_i;
   logic [DATA_W-1:0] imm_i;

   logic              regwrite_o;
   logic              memtoreg_o;
   logic              memread_o;
   logic              memwrite_o;
   logic              branch_o;
   logic [DATA_W-1:0] alu_result_o;
   logic              zero_o;
   logic [DATA_W-1:0] store_data_o;

   modport master (
      output op_i, noop_i, funct_i,
      output rs1_data_i, rs2_data_i, imm_i,
      input  regwrite_o, memtoreg_o, memread_o,
      input  memwrite_o, branch_o,
      input  alu_result_o, zero_o, store_data_o
   );

   modport slave (
      input  op_i, noop_i, funct_i,
      input  rs1_data_i, rs2_data_i, imm_i,
      output regwrite_o, memtoreg_o, memread_o,
      output memwrite_o, branch_o,
      output alu_result_o, zero_o, store_data_o
   );

endinterface

// File: rtl/exu_alu_core.sv
// Combinational ALU: decodes the 3-bit control code and computes the result.
// The multiplier exists only when ALU_MUL_EN is defined.
module exu_alu_core
   import exec_decode_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  aluctl_e           ctl,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] shamt;

   assign shamt = b[SH_W-1:0];

   always_comb begin
      result = '0;
      unique case (ctl)
         ALU_AND: result = a & b;
         ALU_XOR: result = a ^ b;
         ALU_SLL: result = a << shamt;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
`ifdef ALU_MUL_EN
         ALU_MUL: result = a * b;
`endif
         ALU_SRA: result = $signed(a) >>> shamt;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/exec_decode_unit.sv
// Main decode, ALU control decode, operand select and 1-cycle output registers.
// Optional MUL decode under ALU_MUL_EN.
module exec_decode_unit
   import exec_decode_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input logic               clk_i,
   input logic               rst_i,
   exec_decode_unit_if.slave bus
);

   ctrl_t             ctrl;
   aluop_e            aluop;
   logic              alusrc;
   aluctl_e           aluctl;
   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] result;
   logic [6:0]        funct7;
   logic [2:0]        funct3;

   assign funct7 = bus.funct_i[9:3];
   assign funct3 = bus.funct_i[2:0];

   always_comb begin
      ctrl   = '0;
      aluop  = ALUOP_MEM;
      alusrc = 1'b0;
      if (!bus.noop_i) begin
         unique case (1'b1)
            (bus.op_i == OP_R): begin
               ctrl.regwrite = 1'b1;
               aluop         = ALUOP_R;
            end
            (bus.op_i == OP_I): begin
               ctrl.regwrite = 1'b1;
               aluop         = ALUOP_I;
               alusrc        = 1'b1;
            end
            (bus.op_i == OP_LOAD): begin
               ctrl.regwrite = 1'b1;
               ctrl.memtoreg = 1'b1;
               ctrl.memread  = 1'b1;
               alusrc        = 1'b1;
            end
            (bus.op_i == OP_STORE): begin
               ctrl.memwrite = 1'b1;
               alusrc        = 1'b1;
            end
            (bus.op_i == OP_BRANCH): begin
               ctrl.branch = 1'b1;
               aluop       = ALUOP_BR;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      aluctl = ALU_ADD;
      unique case (aluop)
         ALUOP_BR: aluctl = ALU_SUB;
         ALUOP_R: begin
            unique case (bus.funct_i)
               F_AND:   aluctl = ALU_AND;
               F_XOR:   aluctl = ALU_XOR;
               F_SLL:   aluctl = ALU_SLL;
               F_SUB:   aluctl = ALU_SUB;
`ifdef ALU_MUL_EN
               F_MUL:   aluctl = ALU_MUL;
`endif
               default: aluctl = ALU_ADD;
            endcase
         end
         ALUOP_I: begin
            if (funct3 == 3'b101 && funct7 == 7'b0100000)
               aluctl = ALU_SRA;
         end
         default: aluctl = ALU_ADD;
      endcase
   end

   assign opb = alusrc ? bus.imm_i : bus.rs2_data_i;

   exu_alu_core #(
      .DATA_W (DATA_W)
   ) u_alu (
      .ctl    (aluctl),
      .a      (bus.rs1_data_i),
      .b      (opb),
      .result (result)
   );

   // No stall: every register reloads on every rising edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bus.regwrite_o   <= 1'b0;
         bus.memtoreg_o   <= 1'b0;
         bus.memread_o    <= 1'b0;
         bus.memwrite_o   <= 1'b0;
         bus.branch_o     <= 1'b0;
         bus.alu_result_o <= '0;
         bus.zero_o       <= 1'b0;
         bus.store_data_o <= '0;
      end else begin
         bus.regwrite_o   <= ctrl.regwrite;
         bus.memtoreg_o   <= ctrl.memtoreg;
         bus.memread_o    <= ctrl.memread;
         bus.memwrite_o   <= ctrl.memwrite;
         bus.branch_o     <= ctrl.branch;
         bus.alu_result_o <= result;
         bus.zero_o       <= (result == '0);
         bus.store_data_o <= bus.rs2_data_i;
      end
   end

endmodule

// File: tb/tb_exec_decode_unit.sv
// Self-checking bench for exec_decode_unit: directed cases plus random
// instructions checked against a behavioural model (honours ALU_MUL_EN).
module tb_exec_decode_unit;

   localparam int W = 32;
`ifdef ALU_MUL_EN
   localparam bit MULEN = 1'b1;
`else
   localparam bit MULEN = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]   ctl;
      logic [W-1:0] res;
      logic         z;
      logic [W-1:0] sd;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   checks = 0;
   int   failures = 0;

   exec_decode_unit_if #(.DATA_W(W)) bus ();

   exec_decode_unit #(.DATA_W(W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   function automatic exp_t observed();
      exp_t o;
      o.ctl = {bus.regwrite_o, bus.memtoreg_o, bus.memread_o,
               bus.memwrite_o, bus.branch_o};
      o.res = bus.alu_result_o;
      o.z   = bus.zero_o;
      o.sd  = bus.store_data_o;
      return o;
   endfunction

   function automatic logic [W-1:0] sra(input logic [W-1:0] x, input int sh);
      logic [W-1:0] r;
      r = x >> sh;
      if (x[W-1] && sh > 0)
         r = r | ~({W{1'b1}} >> sh);
      return r;
   endfunction

   // Reference: result, control bits and zero flag from the opcode table.
   function automatic exp_t model(input logic [6:0] op, input logic noop,
                                  input logic [9:0] funct,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] rs2,
                                  input logic [W-1:0] imm);
      exp_t e;
      logic [W-1:0] r;
      logic [6:0] f7;
      logic [2:0] f3;
      int sh;
      f7 = funct[9:3];
      f3 = funct[2:0];
      sh = int'(rs2[4:0]);
      e.ctl = 5'b0;
      if (noop) begin
         r = a + rs2;
      end else begin
         case (op)
            7'b0110011: begin
               e.ctl = 5'b10000;
               if (f7 == 7'd0 && f3 == 3'd7) r = a & rs2;
               else if (f7 == 7'd0 && f3 == 3'd4) r = a ^ rs2;
               else if (f7 == 7'd0 && f3 == 3'd1) r = a << sh;
               else if (f7 == 7'h20 && f3 == 3'd0) r = a - rs2;
               else if (f7 == 7'd1 && f3 == 3'd0)
                  r = MULEN ? a * rs2 : a + rs2;
               else r = a + rs2;
            end
            7'b0010011: begin
               e.ctl = 5'b10000;
               if (f7 == 7'h20 && f3 == 3'd5) r = sra(a, int'(imm[4:0]));
               else r = a + imm;
            end
            7'b0000011: begin
               e.ctl = 5'b11100;
               r = a + imm;
            end
            7'b0100011: begin
               e.ctl = 5'b00010;
               r = a + imm;
            end
            7'b1100011: begin
               e.ctl = 5'b00001;
               r = a - rs2;
            end
            default: r = a + rs2;
         endcase
      end
      e.res = r;
      e.z   = (r == 0);
      e.sd  = rs2;
      return e;
   endfunction

   task automatic drive(input logic [6:0] op, input logic noop,
                        input logic [9:0] funct, input logic [W-1:0] a,
                        input logic [W-1:0] rs2, input logic [W-1:0] imm);
      bus.op_i       = op;
      bus.noop_i     = noop;
      bus.funct_i    = funct;
      bus.rs1_data_i = a;
      bus.rs2_data_i = rs2;
      bus.imm_i      = imm;
   endtask

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      exp_t o;
      drive(7'b0110011, 1'b0, 10'd0, 32'd7, 32'd5, 32'd0);
      repeat (2) cycle();
      o = observed();
      checks++;
      if (o !== '0) begin
         failures++;
         $display("FAIL reset_hold got=%h exp=0", o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      o = observed();
      checks++;
      if (o !== '0) begin
         failures++;
         $display("FAIL reset_release got=%h exp=0", o);
      end
   endtask

   task automatic test_directed();
      exp_t o;
      exp_t e;
      @(negedge clk_i);
      drive(7'b0110011, 1'b0, 10'b0000000_000, 32'd7, 32'd5, 32'd99);
      cycle();
      o = observed();
      e = {5'b10000, 32'd12, 1'b0, 32'd5};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL r_add got=%h exp=%h", o, e);
      end
      @(negedge clk_i);
      drive(7'b0110011, 1'b0, 10'b0100000_000, 32'h1234, 32'h1234, 32'd3);
      cycle();
      o = observed();
      e = {5'b10000, 32'd0, 1'b1, 32'h1234};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL r_sub_zero got=%h exp=%h", o, e);
      end
      @(negedge clk_i);
      drive(7'b0010011, 1'b0, 10'b0100000_101, 32'h80000000, 32'd1, 32'd4);
      cycle();
      o = observed();
      e = {5'b10000, 32'hF8000000, 1'b0, 32'd1};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL srai got=%h exp=%h", o, e);
      end
      @(negedge clk_i);
      drive(7'b0100011, 1'b0, 10'd0, 32'h100, 32'hAB, 32'd8);
      cycle();
      o = observed();
      e = {5'b00010, 32'h108, 1'b0, 32'hAB};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL store got=%h exp=%h", o, e);
      end
      @(negedge clk_i);
      drive(7'b0110011, 1'b0, 10'b0000001_000, 32'd3, 32'd5, 32'd0);
      cycle();
      o = observed();
      e = {5'b10000, (MULEN ? 32'd15 : 32'd8), 1'b0, 32'd5};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL mul got=%h exp=%h", o, e);
      end
      @(negedge clk_i);
      drive(7'b0110011, 1'b0, 10'b0000000_001, 32'd1, 32'h25, 32'd0);
      cycle();
      o = observed();
      e = {5'b10000, 32'd32, 1'b0, 32'h25};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL sll_shamt got=%h exp=%h", o, e);
      end
      @(negedge clk_i);
      drive(7'b1100011, 1'b0, 10'd0, 32'd9, 32'd9, 32'd4);
      cycle();
      o = observed();
      e = {5'b00001, 32'd0, 1'b1, 32'd9};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL branch_eq got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_bubble();
      exp_t o;
      exp_t e;
      @(negedge clk_i);
      drive(7'b0000011, 1'b1, 10'd0, 32'd40, 32'd2, 32'd100);
      cycle();
      o = observed();
      e = {5'b00000, 32'd42, 1'b0, 32'd2};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL bubble_load got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_reset_midstream();
      exp_t o;
      exp_t e;
      @(negedge clk_i);
      drive(7'b0110011, 1'b0, 10'd0, 32'd7, 32'd5, 32'd0);
      cycle();
      @(negedge clk_i);
      drive(7'b0000011, 1'b0, 10'd0, 32'd16, 32'd1, 32'd4);
      #2;
      rst_i = 1'b0;
      #1;
      o = observed();
      checks++;
      if (o !== '0) begin
         failures++;
         $display("FAIL reset_async got=%h exp=0", o);
      end
      cycle();
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      o = observed();
      checks++;
      if (o !== '0) begin
         failures++;
         $display("FAIL reset_discard got=%h exp=0", o);
      end
      cycle();
      o = observed();
      e = model(7'b0000011, 1'b0, 10'd0, 32'd16, 32'd1, 32'd4);
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL reset_first_capture got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [6];
      logic [9:0] fs [8];
      logic [6:0] op;
      logic [9:0] f;
      logic [W-1:0] a, b, imm;
      logic noop;
      exp_t o;
      exp_t e;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011,
              7'b0100011, 7'b1100011, 7'b1111111};
      fs = '{10'b0000000_111, 10'b0000000_100, 10'b0000000_001,
             10'b0000000_000, 10'b0100000_000, 10'b0000001_000,
             10'b0100000_101, 10'b0000000_101};
      for (int i = 0; i < 300; i++) begin
         op = ops[$urandom_range(0, 5)];
         if ($urandom_range(0, 7) == 0) op = 7'($urandom);
         f = fs[$urandom_range(0, 7)];
         if ($urandom_range(0, 7) == 0) f = 10'($urandom);
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? a : $urandom;
         imm = ($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(0, 40));
         noop = ($urandom_range(0, 9) == 0);
         @(negedge clk_i);
         drive(op, noop, f, a, b, imm);
         cycle();
         o = observed();
         e = model(op, noop, f, a, b, imm);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL rand_%0d op=%b f=%b got=%h exp=%h",
                     i, op, f, o, e);
         end
      end
   endtask

   initial begin
      drive(7'd0, 1'b0, 10'd0, '0, '0, '0);
      test_reset();
      test_directed();
      test_bubble();
      test_reset_midstream();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_decode_unit.md
EXEC_DECODE_UNIT -- requirements
Module: exec_decode_unit

Interface
REQ-001 Parameter DATA_W, default 32: operand/result width; the shift amount is the low log2(DATA_W) bits of operand B.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 op_i  in  7  instruction opcode [6:0].
REQ-006 noop_i  in  1  bubble; forces all control outputs to 0.
REQ-007 funct_i  in  10  {funct7, funct3}.
REQ-008 rs1_data_i  in  DATA_W  operand A.
REQ-009 rs2_data_i  in  DATA_W  register operand B.
REQ-010 imm_i  in  DATA_W  sign-extended immediate.
REQ-011 regwrite_o, memtoreg_o, memread_o, memwrite_o, branch_o  out  1 each  registered control bits.
REQ-012 alu_result_o  out  DATA_W  registered ALU result.
REQ-013 zero_o  out  1  registered (result == 0).
REQ-014 store_data_o  out  DATA_W  registered rs2_data_i.

Function
REQ-015 The main decoder SHALL map opcodes as follows, where ALUOp/ALUSrc are internal:
- 0110011 R: RegWrite=1, ALUOp=10, ALUSrc=0
- 0010011 I: RegWrite=1, ALUOp=11, ALUSrc=1
- 0000011 load: RegWrite=1, MemtoReg=1, MemRead=1, ALUOp=00, ALUSrc=1
- 0100011 store: MemWrite=1, ALUOp=00, ALUSrc=1
- 1100011 branch: Branch=1, ALUOp=01, ALUSrc=0
REQ-016 Any other opcode, or noop_i=1, SHALL give all control bits 0, with ALUOp=00 and ALUSrc=0.
REQ-017 Operand B SHALL be imm_i when ALUSrc=1, otherwise rs2_data_i.
REQ-018 ALU control (3-bit) SHALL be derived as follows:
- ALUOp 00 gives ADD; ALUOp 01 gives SUB.
- ALUOp 10: funct 0000000_111 AND, 0000000_100 XOR, 0000000_001 SLL, 0000000_000 ADD, 0100000_000 SUB, 0000001_000 MUL.
- ALUOp 11: funct3 000 ADD; funct3 101 with funct7 0100000 SRA.
- Any other combination gives ADD.
REQ-019 ALU control encodings SHALL be: AND=000, XOR=001, SLL=010, ADD=011, SUB=100, MUL=101, SRA=110; code 111 SHALL yield result 0.
REQ-020 ADD, SUB and MUL SHALL be modulo 2^DATA_W, keeping the low DATA_W bits, with no overflow flag.
REQ-021 SRA SHALL be an arithmetic shift; SLL SHALL fill with zeros.
REQ-022 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-023 Every registered output SHALL update every cycle; there is no hold or stall.
REQ-024 On a bubble, the ALU result SHALL still be computed and registered, but all control bits SHALL be 0.

Reset
REQ-025 While rst_i=0, all outputs SHALL be 0, including zero_o; this takes effect immediately and is independent of clk_i.
REQ-026 The first capture after reset release SHALL occur on the first rising edge with rst_i=1.
REQ-027 Asserting reset mid-stream SHALL discard the in-flight result.

Configuration
REQ-028 Macro ALU_MUL_EN SHALL control MUL support.
REQ-029 With ALU_MUL_EN defined, funct 0000001_000 under ALUOp 10 SHALL decode to MUL.
REQ-030 Without ALU_MUL_EN, that funct SHALL decode to ADD, no multiplier SHALL be synthesized, and code 101 SHALL yield 0.

Structure
REQ-031 The shared package exec_decode_pkg SHALL hold the opcode constants, the ALUOp encodings and the ALU control encodings.
REQ-032 The arithmetic datapath SHALL be one sub-module, exu_alu_core, containing the operation decode and the combinational ALU.
REQ-033 The main decoder, ALU-control decoder, operand mux and output registers SHALL live in the top module.

Verification
REQ-034 R ADD: op=0110011, funct=0000000_000, A=7, B=5 -> next cycle result=12, regwrite=1, zero=0.
REQ-035 R SUB to zero: funct=0100000_000, A=B=0x1234 -> result=0, zero=1.
REQ-036 SRAI: op=0010011, funct=0100000_101, A=0x80000000, imm=4 -> result=0xF8000000, regwrite=1.
REQ-037 Store: op=0100011, A=0x100, imm=8, rs2=0xAB -> result=0x108, memwrite=1, store_data=0xAB, regwrite=0.
REQ-038 MUL: funct=0000001_000, A=3, B=5 -> result=15 with ALU_MUL_EN, 8 without.
REQ-039 Bubble and reset: a load with noop_i=1 -> all control bits 0; rst_i low mid-cycle -> outputs 0 immediately.
